// File: rtl/main_memory_bank.sv
// main_memory_bank
//   Word-addressed backing store that sits behind the cache controller. It
//   serves block refills on read misses and single-word write-throughs.
//   Every request runs for a fixed latency and finishes with a one-cycle
//   MemReady pulse.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for a request; write has priority over read
//   BUSY  | latency countdown on latched op/address/data; commit at zero
//   DONE  | MemReady high for this single cycle, then back to IDLE
//
// Ports
//   CLK          rising-edge clock
//   RST          asynchronous active-low reset; clears storage and aborts
//                any transaction in flight
//   MemReadMem   block read request
//   MemWriteMem  word write request
//   MemAddress   word address
//   MemDataIn    write data
//   MemDataOut   last block read; word i at [DATA_W*i +: DATA_W]
//   MemReady     one-cycle completion pulse
//   MemBusy      high while a transaction is in BUSY or DONE
//
// Optional feature (macro MAIN_MEM_PERF_CNT_EN)
//   Adds RdCount / WrCount: saturating 16-bit counts of completed reads
//   and writes.
module main_memory_bank #(
   parameter int ADDR_W      = 10,
   parameter int DATA_W      = 32,
   parameter int BLOCK_WORDS = 4,
   parameter int READ_LAT    = 4,
   parameter int WRITE_LAT   = 4
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          MemReadMem,
   input  logic                          MemWriteMem,
   input  logic [ADDR_W-1:0]             MemAddress,
   input  logic [DATA_W-1:0]             MemDataIn,
   output logic [DATA_W*BLOCK_WORDS-1:0] MemDataOut,
   output logic                          MemReady,
   output logic                          MemBusy
`ifdef MAIN_MEM_PERF_CNT_EN
   ,
   output logic [15:0]                   RdCount,
   output logic [15:0]                   WrCount
`endif
);

   localparam int DEPTH   = 2 ** ADDR_W;
   localparam int OFF_W   = $clog2(BLOCK_WORDS);
   localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
   localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LAT - 1);
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LAT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                          state_q, state_d;
   logic                            op_wr_q, op_wr_d;
   logic [ADDR_W-1:0]               addr_q, addr_d;
   logic [DATA_W-1:0]               wdata_q, wdata_d;
   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic [DATA_W*BLOCK_WORDS-1:0]   dout_q, dout_d;
   logic [DATA_W*BLOCK_WORDS-1:0]   blk_rdata;
   logic                            mem_we;
   logic                            done_entry;

   logic [DATA_W-1:0]               mem_q [DEPTH];

   // Whole block around the latched address; the low offset bits of the
   // request are discarded so any word of the block fetches the same block.
   always_comb begin
      blk_rdata = '0;
      for (int i = 0; i < BLOCK_WORDS; i++) begin
         blk_rdata[DATA_W*i +: DATA_W] = mem_q[{addr_q[ADDR_W-1:OFF_W], OFF_W'(i)}];
      end
   end

   always_comb begin
      state_d    = state_q;
      op_wr_d    = op_wr_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      dout_d     = dout_q;
      mem_we     = 1'b0;
      done_entry = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (MemWriteMem) begin
               op_wr_d = 1'b1;
               addr_d  = MemAddress;
               wdata_d = MemDataIn;
               cnt_d   = WR_LOAD;
               state_d = ST_BUSY;
            end else if (MemReadMem) begin
               op_wr_d = 1'b0;
               addr_d  = MemAddress;
               wdata_d = MemDataIn;
               cnt_d   = RD_LOAD;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               done_entry = 1'b1;
               state_d    = ST_DONE;
               if (op_wr_q) begin
                  mem_we = 1'b1;
               end else begin
                  dout_d = blk_rdata;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= ST_IDLE;
         op_wr_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         op_wr_q <= op_wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
      end
   end

   // Storage is cleared by reset, so it lives in its own flop block with a
   // clear loop rather than a full-array next-state copy.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (mem_we) begin
         mem_q[addr_q] <= wdata_q;
      end
   end

   assign MemDataOut = dout_q;
   assign MemReady   = (state_q == ST_DONE);
   assign MemBusy    = (state_q != ST_IDLE);

`ifdef MAIN_MEM_PERF_CNT_EN
   logic [15:0] rd_cnt_q, rd_cnt_d;
   logic [15:0] wr_cnt_q, wr_cnt_d;

   always_comb begin
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      if (done_entry) begin
         if (op_wr_q) begin
            if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
         end else begin
            if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end

   assign RdCount = rd_cnt_q;
   assign WrCount = wr_cnt_q;
`else
   logic unused_done_entry;
   assign unused_done_entry = done_entry;
`endif

endmodule
